// File: rtl/rcv_sequencer.sv
// UART receive control sequencer: synchronizes the serial line, qualifies the
// start bit at mid-bit, latches per-packet timing, gates the bit timer and
// checks the stop bit before handing the byte to the receive buffer.
module rcv_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_in,
  input  logic [13:0] cfg_bit_period,
  input  logic [3:0]  cfg_data_size,
  input  logic        packet_done,
  input  logic        stop_bit,
  input  logic        data_read,
  output logic        enable_timer,
  output logic [13:0] bit_period,
  output logic [3:0]  data_size,
  output logic        load_buffer,
  output logic        data_ready,
  output logic        framing_error,
  output logic        overrun_error,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    RECEIVE   = 3'd2,
    STOP_CHK  = 3'd3,
    LOAD      = 3'd4
  } state_t;

  state_t      state;
  logic        s1, s2, s3;
  logic [13:0] hc;
  logic        start_edge;
  logic [13:0] bp_clamped;
  logic [3:0]  ds_clamped;
  logic [13:0] half_m1;

  // s3 holds the previous s2 so a falling line is seen exactly once
  assign start_edge = ~s2 & s3;

  // Clamp the incoming configuration and derive the start-bit sample point
  always_comb begin
    bp_clamped = cfg_bit_period;
    if (cfg_bit_period < 14'd4) bp_clamped = 14'd4;
    ds_clamped = cfg_data_size;
    if (cfg_data_size < 4'd5) ds_clamped = 4'd5;
    else if (cfg_data_size > 4'd8) ds_clamped = 4'd8;
    half_m1 = (bit_period >> 1) - 14'd1;
  end

  // Two-flop synchronizer plus one history flop; idle line is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= serial_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Receive FSM; outputs are registered alongside the state they decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hc            <= 14'd0;
      enable_timer  <= 1'b0;
      load_buffer   <= 1'b0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
      bit_period    <= 14'd10;
      data_size     <= 4'd8;
    end else begin
      load_buffer <= 1'b0;
      // Consumer acknowledge; a coinciding LOAD below overrides this
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_edge) begin
            bit_period    <= bp_clamped;
            data_size     <= ds_clamped;
            framing_error <= 1'b0;
            hc            <= 14'd0;
            state         <= START_CHK;
            busy          <= 1'b1;
          end
        end
        START_CHK: begin
          if (hc == half_m1) begin
            if (!s2) begin
              state        <= RECEIVE;
              enable_timer <= 1'b1;
            end else begin
              // Line went back high before mid start bit: a glitch
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            hc <= hc + 14'd1;
          end
        end
        RECEIVE: begin
          if (packet_done) begin
            state        <= STOP_CHK;
            enable_timer <= 1'b0;
          end
        end
        STOP_CHK: begin
          if (stop_bit) begin
            state       <= LOAD;
            load_buffer <= 1'b1;
          end else begin
            framing_error <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        end
        LOAD: begin
          data_ready <= 1'b1;
          if (data_ready && !data_read) overrun_error <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          enable_timer <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rcv_sequencer.sv
// Directed bench for rcv_sequencer: the bench plays the bit timer itself,
// asserting packet_done once enable_timer has been high bit_period*(data_size+1)
// cycles, and checks sequencing, flags, clamping and reset behaviour.
module tb_rcv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        serial_in;
  logic [13:0] cfg_bit_period;
  logic [3:0]  cfg_data_size;
  logic        packet_done;
  logic        stop_bit;
  logic        data_read;
  logic        enable_timer;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        load_buffer;
  logic        data_ready;
  logic        framing_error;
  logic        overrun_error;
  logic        busy;

  int total = 0;
  int bad   = 0;

  rcv_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .cfg_bit_period (cfg_bit_period),
    .cfg_data_size  (cfg_data_size),
    .packet_done    (packet_done),
    .stop_bit       (stop_bit),
    .data_read      (data_read),
    .enable_timer   (enable_timer),
    .bit_period     (bit_period),
    .data_size      (data_size),
    .load_buffer    (load_buffer),
    .data_ready     (data_ready),
    .framing_error  (framing_error),
    .overrun_error  (overrun_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one packet from the falling start edge until the FSM returns to idle
  task automatic send_packet(input int n_timer, input bit stop, input bit rd_at_load,
                             input bit mid_cfg, input logic [13:0] mid_bp, input logic [3:0] mid_ds,
                             output int start_lat, output int chk_cyc, output int en_cyc,
                             output int loads, output int pd_to_load, output int pd_to_dr,
                             output bit fe_at_start);
    int  t;
    int  pd_cyc;
    bit  seen_busy;
    bit  seen_en;
    bit  done;
    start_lat = -1; chk_cyc = 0; en_cyc = 0; loads = 0;
    pd_to_load = -1; pd_to_dr = -1; fe_at_start = 1'b1;
    pd_cyc = -1; seen_busy = 0; seen_en = 0; done = 0; t = 0;
    stop_bit  = stop;
    serial_in = 1'b0;
    while (!done && t < 3000) begin
      tick();
      t++;
      packet_done = 1'b0;
      data_read   = 1'b0;
      if (busy && !seen_busy) begin
        seen_busy   = 1;
        start_lat   = t;
        fe_at_start = framing_error;
      end
      if (busy && !seen_en && !enable_timer) chk_cyc++;
      if (enable_timer) begin
        if (!seen_en) begin
          seen_en   = 1;
          serial_in = 1'b1;
          if (mid_cfg) begin
            cfg_bit_period = mid_bp;
            cfg_data_size  = mid_ds;
          end
        end
        en_cyc++;
        if (en_cyc == n_timer) begin
          packet_done = 1'b1;
          pd_cyc      = t;
        end
      end
      if (load_buffer) begin
        loads++;
        if (pd_cyc >= 0) pd_to_load = t - pd_cyc;
        if (rd_at_load) data_read = 1'b1;
      end
      if (seen_en && !busy) begin
        done = 1;
        if (data_ready && pd_cyc >= 0) pd_to_dr = t - pd_cyc;
      end
    end
    packet_done = 1'b0;
    data_read   = 1'b0;
    serial_in   = 1'b1;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL packet_timeout: got no return to idle within %0d cycles, need completion", t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; serial_in = 1'b1; cfg_bit_period = 14'd10; cfg_data_size = 4'd8;
    packet_done = 1'b0; stop_bit = 1'b1; data_read = 1'b0;
    tick(); tick();
    total++; if (enable_timer !== 1'b0) begin bad++; $display("FAIL rst_enable: got %b need 0", enable_timer); end
    total++; if (load_buffer !== 1'b0) begin bad++; $display("FAIL rst_load: got %b need 0", load_buffer); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b need 0", data_ready); end
    total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL rst_framing: got %b need 0", framing_error); end
    total++; if (overrun_error !== 1'b0) begin bad++; $display("FAIL rst_overrun: got %b need 0", overrun_error); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b need 0", busy); end
    total++; if (bit_period !== 14'd10) begin bad++; $display("FAIL rst_bit_period: got %0d need 10", bit_period); end
    total++; if (data_size !== 4'd8) begin bad++; $display("FAIL rst_data_size: got %0d need 8", data_size); end
    rst = 1'b0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_rst: busy got %b need 0", busy); end
  endtask

  task automatic test_normal();
    int sl, cc, ec, ld, pl, pr;
    bit fs;
    cfg_bit_period = 14'd10; cfg_data_size = 4'd8;
    send_packet(90, 1'b1, 1'b0, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    total++; if (sl !== 3) begin bad++; $display("FAIL normal_start_latency: got %0d need 3", sl); end
    total++; if (cc !== 5) begin bad++; $display("FAIL normal_start_chk: got %0d need 5", cc); end
    total++; if (ec !== 90) begin bad++; $display("FAIL normal_enable_cycles: got %0d need 90", ec); end
    total++; if (ld !== 1) begin bad++; $display("FAIL normal_loads: got %0d need 1", ld); end
    total++; if (pl !== 2) begin bad++; $display("FAIL normal_done_to_load: got %0d need 2", pl); end
    total++; if (pr !== 3) begin bad++; $display("FAIL normal_done_to_ready: got %0d need 3", pr); end
    total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL normal_ready: got %b need 1", data_ready); end
    total++; if (framing_error !== 1'b0 || overrun_error !== 1'b0) begin
      bad++; $display("FAIL normal_errors: got fe=%b oe=%b need 0/0", framing_error, overrun_error); end
    total++; if (bit_period !== 14'd10 || data_size !== 4'd8) begin
      bad++; $display("FAIL normal_latched: got %0d/%0d need 10/8", bit_period, data_size); end
  endtask

  task automatic test_glitch();
    int  busy_cnt;
    bit  en_seen;
    busy_cnt = 0; en_seen = 0;
    serial_in = 1'b0;
    tick(); tick();
    serial_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (enable_timer) en_seen = 1;
    end
    total++; if (busy_cnt !== 5) begin bad++; $display("FAIL glitch_start_chk: got %0d need 5", busy_cnt); end
    total++; if (en_seen !== 1'b0) begin bad++; $display("FAIL glitch_enable: got %b need 0", en_seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b need 0", busy); end
    total++; if (data_ready !== 1'b1 || framing_error !== 1'b0 || overrun_error !== 1'b0) begin
      bad++; $display("FAIL glitch_flags: got dr=%b fe=%b oe=%b need 1/0/0", data_ready, framing_error, overrun_error); end
  endtask

  task automatic test_framing();
    int sl, cc, ec, ld, pl, pr;
    bit fs;
    data_read = 1'b1; tick(); data_read = 1'b0;
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL read_clear: got %b need 0", data_ready); end
    send_packet(90, 1'b0, 1'b0, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    total++; if (framing_error !== 1'b1) begin bad++; $display("FAIL framing_set: got %b need 1", framing_error); end
    total++; if (ld !== 0) begin bad++; $display("FAIL framing_no_load: got %0d need 0", ld); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL framing_ready: got %b need 0", data_ready); end
    stop_bit = 1'b1;
    send_packet(90, 1'b1, 1'b0, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    total++; if (fs !== 1'b0) begin bad++; $display("FAIL framing_clear_on_start: got %b need 0", fs); end
    total++; if (framing_error !== 1'b0 || ld !== 1 || data_ready !== 1'b1) begin
      bad++; $display("FAIL framing_recover: got fe=%b loads=%0d dr=%b need 0/1/1", framing_error, ld, data_ready); end
  endtask

  task automatic test_overrun();
    int sl, cc, ec, ld, pl, pr;
    bit fs;
    send_packet(90, 1'b1, 1'b0, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    total++; if (overrun_error !== 1'b1 || data_ready !== 1'b1) begin
      bad++; $display("FAIL overrun_set: got oe=%b dr=%b need 1/1", overrun_error, data_ready); end
    data_read = 1'b1; tick(); data_read = 1'b0;
    total++; if (overrun_error !== 1'b0 || data_ready !== 1'b0) begin
      bad++; $display("FAIL overrun_read_clear: got oe=%b dr=%b need 0/0", overrun_error, data_ready); end
    send_packet(90, 1'b1, 1'b0, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    send_packet(90, 1'b1, 1'b1, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    total++; if (data_ready !== 1'b1 || overrun_error !== 1'b0 || ld !== 1) begin
      bad++; $display("FAIL read_on_load: got dr=%b oe=%b loads=%0d need 1/0/1", data_ready, overrun_error, ld); end
  endtask

  task automatic test_clamp();
    int sl, cc, ec, ld, pl, pr;
    bit fs;
    cfg_bit_period = 14'd2; cfg_data_size = 4'd12;
    send_packet(36, 1'b1, 1'b0, 1'b1, 14'd20, 4'd5, sl, cc, ec, ld, pl, pr, fs);
    total++; if (bit_period !== 14'd4 || data_size !== 4'd8) begin
      bad++; $display("FAIL clamp_high: got %0d/%0d need 4/8", bit_period, data_size); end
    total++; if (cc !== 2 || ec !== 36) begin
      bad++; $display("FAIL clamp_timing: got chk=%0d en=%0d need 2/36", cc, ec); end
    send_packet(120, 1'b1, 1'b0, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    total++; if (bit_period !== 14'd20 || data_size !== 4'd5 || cc !== 10) begin
      bad++; $display("FAIL relatch: got %0d/%0d chk=%0d need 20/5/10", bit_period, data_size, cc); end
    cfg_bit_period = 14'd0; cfg_data_size = 4'd3;
    send_packet(24, 1'b1, 1'b0, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    total++; if (bit_period !== 14'd4 || data_size !== 4'd5 || ld !== 1) begin
      bad++; $display("FAIL clamp_low: got %0d/%0d loads=%0d need 4/5/1", bit_period, data_size, ld); end
  endtask

  task automatic test_reset_mid();
    int sl, cc, ec, ld, pl, pr;
    int en_cnt;
    bit fs;
    en_cnt = 0;
    cfg_bit_period = 14'd16; cfg_data_size = 4'd6;
    serial_in = 1'b0;
    for (int t = 0; t < 300 && en_cnt < 40; t++) begin
      tick();
      if (enable_timer) begin
        serial_in = 1'b1;
        en_cnt++;
      end
    end
    total++; if (en_cnt !== 40 || bit_period !== 14'd16) begin
      bad++; $display("FAIL mid_setup: got en=%0d bp=%0d need 40/16", en_cnt, bit_period); end
    #1 rst = 1'b1;
    #1;
    total++; if (enable_timer !== 1'b0 || busy !== 1'b0 || load_buffer !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctrl: got en=%b busy=%b ld=%b need 0/0/0", enable_timer, busy, load_buffer); end
    total++; if (data_ready !== 1'b0 || framing_error !== 1'b0 || overrun_error !== 1'b0) begin
      bad++; $display("FAIL mid_rst_flags: got dr=%b fe=%b oe=%b need 0/0/0", data_ready, framing_error, overrun_error); end
    total++; if (bit_period !== 14'd10 || data_size !== 4'd8) begin
      bad++; $display("FAIL mid_rst_cfg: got %0d/%0d need 10/8", bit_period, data_size); end
    #2 rst = 1'b0;
    tick(); tick();
    cfg_bit_period = 14'd10; cfg_data_size = 4'd8;
    send_packet(90, 1'b1, 1'b0, 1'b0, 14'd0, 4'd0, sl, cc, ec, ld, pl, pr, fs);
    total++; if (ld !== 1 || ec !== 90 || data_ready !== 1'b1 || overrun_error !== 1'b0) begin
      bad++; $display("FAIL after_rst_packet: got loads=%0d en=%0d dr=%b oe=%b need 1/90/1/0", ld, ec, data_ready, overrun_error); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_glitch();
    test_framing();
    test_overrun();
    test_clamp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rcv_sequencer.md
# rcv_sequencer

Control sequencer for the UART receiver's bit/packet timer. It synchronizes the raw serial line and qualifies the start bit at half a bit period. It latches the per-packet timing configuration, gates the timer's `enable_timer`, and checks the stop bit once the timer reports `packet_done`. It sits between the serial pin, the timer, the receive shift register and the receive data buffer, and reports `data_ready`, `framing_error` and `overrun_error` to the consumer.

## Interface
- No parameters; widths are fixed to match the timer (14-bit bit period, 4-bit data size).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `serial_in`  in  1  raw serial line; idle high; not synchronous to `clk`.
- `cfg_bit_period`  in  14  clocks per bit; clamped to a minimum of 4.
- `cfg_data_size`  in  4  data bits per packet; clamped to the range 5..8.
- `packet_done`  in  1  timer rollover pulse, asserted at mid-stop-bit.
- `stop_bit`  in  1  last bit captured by the shift register.
- `data_read`  in  1  consumer acknowledge, one-cycle pulse.
- `enable_timer`  out  1  timer count enable.
- `bit_period`  out  14  latched, clamped bit period driven to the timer.
- `data_size`  out  4  latched, clamped data size driven to the timer.
- `load_buffer`  out  1  one-cycle pulse that copies the shift register into the buffer.
- `data_ready`  out  1  buffer holds an unread byte.
- `framing_error`  out  1  the last packet's stop bit was 0.
- `overrun_error`  out  1  an unread byte was overwritten.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Synchronizer:** `serial_in` passes through flops s1→s2. The start edge is defined as s2==0 while the previous s2 (s3) was 1. All three flops reset to 1.
- **FSM states:** IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD. Outputs are Moore decodes of state except where noted.
- **IDLE:**
  - On a start edge: latch the clamped `cfg_bit_period` and `cfg_data_size` into `bit_period` and `data_size`.
  - Same edge: clear `framing_error`, zero the half-bit counter hc, and go to START_CHK.
- **START_CHK:**
  - hc increments each cycle.
  - When hc == (bit_period>>1)−1, sample s2.
  - s2==0 → RECEIVE. s2==1 → IDLE; this is a glitch, and no flags change.
- **RECEIVE:**
  - `enable_timer`=1.
  - On `packet_done`=1 → STOP_CHK.
  - Timing from the timer: the first shift occurs `bit_period` clocks after entry, at mid data bit 0. `packet_done` occurs at mid stop bit, after data_size+1 rollovers.
- **STOP_CHK:** lasts one cycle and samples `stop_bit`.
  - `stop_bit`==1 → LOAD.
  - `stop_bit`==0 → set `framing_error` and go to IDLE. No load occurs and `data_ready` is unchanged.
- **LOAD:** lasts one cycle.
  - `load_buffer`=1, `data_ready` set, then → IDLE.
  - If `data_ready` was already 1 and `data_read` is 0 this cycle, set `overrun_error`.
- **Handshake:**
  - `data_read` clears `data_ready` and `overrun_error` on the next edge.
  - When `data_read` coincides with LOAD, the load wins: `data_ready` stays 1 and no overrun is flagged.
- **Clamping:**
  - `cfg_bit_period` < 4 → 4.
  - `cfg_data_size` < 5 → 5; > 8 → 8.
  - Config changes outside IDLE are ignored until the next start edge.
- **Line state after a packet:** the line must return high before a new start edge can be detected, because the edge requires the previous s2 to be 1.

## Timing
- **Reset values:**
  - state IDLE, hc 0.
  - `enable_timer`, `load_buffer`, `data_ready`, `framing_error`, `overrun_error`, `busy`: all 0.
  - `bit_period`=10, `data_size`=8.
- **Start-edge latency:** if `serial_in` falls before edge k, the state is START_CHK after edge k+2.
- **Start-bit check:** exactly bit_period>>1 cycles are spent in START_CHK.
- **Timer enable:** `enable_timer` rises the cycle after the check passes. It falls the cycle after `packet_done` is seen.
- **Stop-bit outcome:** `load_buffer` pulses exactly 2 cycles after the `packet_done` cycle (STOP_CHK, then LOAD). `data_ready` is visible 3 cycles after it.
- **Reset mid-packet:** `rst` in any state returns to IDLE immediately. Outputs go to their reset values and no partial load occurs.
- **Back-to-back packets:** after LOAD, a falling edge arriving ≥1 cycle after returning to IDLE is accepted.

## Test plan
- **Normal byte:** `cfg_bit_period`=10, size 8, byte 0xA5 with stop=1.
  - START_CHK lasts 5 cycles; `enable_timer` is high for 90 cycles.
  - `load_buffer` pulses once; `data_ready`=1; no errors.
- **Glitch:** `serial_in` low for 2 cycles only.
  - FSM returns to IDLE after 5 cycles in START_CHK.
  - `enable_timer` never asserts; `busy` drops; flags unchanged.
- **Framing error:** `stop_bit`=0 at STOP_CHK.
  - `framing_error`=1, no `load_buffer`.
  - The next valid start edge clears `framing_error`.
- **Overrun:** two packets with no `data_read`.
  - The second LOAD sets `overrun_error`=1.
  - A `data_read` pulse clears both `data_ready` and `overrun_error`.
  - `data_read` on the LOAD cycle → `data_ready` stays 1, no overrun.
- **Clamp and latch:** `cfg_bit_period`=2, `cfg_data_size`=12 → outputs `bit_period`=4, `data_size`=8.
  - Changing the config to 20/5 mid-RECEIVE leaves the outputs unchanged until the next start edge.
- **Reset mid-RECEIVE:** assert `rst` at cycle 40 of a packet.
  - All outputs return to reset values asynchronously; state is IDLE.
  - The following packet receives correctly.
